// File: rtl/enc8to3_q.sv
// -----------------------------------------------------------------------------
// enc8to3_q -- queued 8-to-3 priority encoder
//
// Requests on i are latched into a pending bitmap. Whenever the output slot is
// free (no valid code, or the current one is being acknowledged), the highest
// pending bit is issued as a registered binary code on y with v=1 and removed
// from the bitmap. If a request arrives for a bit that is already pending and
// is not being issued on that edge, the request is lost and the sticky ovf
// flag is raised.
//
// Ports
//   clk   in   1  rising-edge clock
//   rst_n in   1  asynchronous active-low reset
//   i     in   8  request lines, bit n requests code n (multi-hot allowed)
//   en    in   1  1 = capture requests and issue codes; 0 = freeze pend
//   ack   in   1  consumer accepts the current code (only meaningful when v=1)
//   clr   in   1  clears ovf (a simultaneous new overflow takes priority)
//   y     out  3  registered code of the issued request
//   v     out  1  y holds a valid, not yet accepted code
//   pend  out  8  registered pending-request bitmap
//   ovf   out  1  sticky lost-request flag
// -----------------------------------------------------------------------------
module enc8to3_q (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i,
   input  logic       en,
   input  logic       ack,
   input  logic       clr,
   output logic [2:0] y,
   output logic       v,
   output logic [7:0] pend,
   output logic       ovf
);

   logic       slot_free;
   logic       issue;
   logic [2:0] top_idx;
   logic [7:0] issue_mask;
   logic [7:0] req;
   logic       ovf_set;
   logic [7:0] pend_next;

   // Highest set pending bit; bit 7 has priority.
   // NOTE: every signal driven in always_comb gets a default first so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      top_idx = 3'd0;
      for (int n = 0; n < 8; n++) begin
         if (pend[n]) top_idx = 3'(n);
      end
   end

   always_comb begin
      slot_free  = !v || ack;
      issue      = en && slot_free && (pend != 8'h00);
      issue_mask = issue ? (8'h01 << top_idx) : 8'h00;
      req        = en ? i : 8'h00;
      // A request for a bit that stays pending across this edge is lost. A bit
      // being issued right now can be re-armed by a new request (set wins).
      ovf_set    = |(req & pend & ~issue_mask);
      pend_next  = (pend & ~issue_mask) | req;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order between blocks.
   // NOTE: all four registers are plain flops (no memory array), so every one
   // of them is cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y    <= 3'd0;
         v    <= 1'b0;
         pend <= 8'h00;
         ovf  <= 1'b0;
      end else begin
         pend <= pend_next;

         if (issue) begin
            y <= top_idx;
            v <= 1'b1;
         end else if (ack) begin
            // y keeps its last value while v is low.
            v <= 1'b0;
         end

         if (ovf_set)  ovf <= 1'b1;
         else if (clr) ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_enc8to3_q.sv
// -----------------------------------------------------------------------------
// tb_enc8to3_q -- self-checking bench for enc8to3_q
//
// A behavioural model (bit arrays, plain loops) tracks the expected outputs and
// is compared against the DUT on every falling edge. Directed sequences add
// hand-computed literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_enc8to3_q;

   logic       clk;
   logic       rst_n;
   logic [7:0] i;
   logic       en;
   logic       ack;
   logic       clr;
   logic [2:0] y;
   logic       v;
   logic [7:0] pend;
   logic       ovf;

   int errors = 0;
   int checks = 0;

   enc8to3_q dut (
      .clk   (clk),
      .rst_n (rst_n),
      .i     (i),
      .en    (en),
      .ack   (ack),
      .clr   (clr),
      .y     (y),
      .v     (v),
      .pend  (pend),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_pend [8];
   int m_y;
   bit m_v;
   bit m_ovf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 8; n++) m_pend[n] = 1'b0;
         m_y   = 0;
         m_v   = 1'b0;
         m_ovf = 1'b0;
      end else begin
         int  sel;
         bit  lost;
         sel  = -1;
         lost = 1'b0;
         if (en && (!m_v || ack)) begin
            for (int n = 7; n >= 0; n--) begin
               if (m_pend[n]) begin
                  sel = n;
                  break;
               end
            end
         end
         if (sel >= 0) m_pend[sel] = 1'b0;
         if (en) begin
            for (int n = 0; n < 8; n++) begin
               if (i[n]) begin
                  if (m_pend[n]) lost = 1'b1;
                  else m_pend[n] = 1'b1;
               end
            end
         end
         if (sel >= 0) begin
            m_y = sel;
            m_v = 1'b1;
         end else if (ack) begin
            m_v = 1'b0;
         end
         if (lost)     m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
      end
   end

   function automatic logic [7:0] model_pend();
      logic [7:0] r;
      for (int n = 0; n < 8; n++) r[n] = m_pend[n];
      return r;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("cyc_y",    {5'd0, y},      8'(m_y));
      check("cyc_v",    {7'd0, v},      {7'd0, m_v});
      check("cyc_pend", pend,           model_pend());
      check("cyc_ovf",  {7'd0, ovf},    {7'd0, m_ovf});
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [2:0] ey, input logic ev,
                             input logic [7:0] ep, input logic eo);
      check({name, "_y"},    {5'd0, y},   {5'd0, ey});
      check({name, "_v"},    {7'd0, v},   {7'd0, ev});
      check({name, "_pend"}, pend,        ep);
      check({name, "_ovf"},  {7'd0, ovf}, {7'd0, eo});
   endtask

   initial begin
      rst_n = 1'b0;
      i = 8'h00; en = 1'b1; ack = 1'b1; clr = 1'b0;
      #12;
      expect_out("reset", 3'd0, 1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      tick();

      // Single request
      i = 8'h20; tick();
      expect_out("single_cap", 3'd0, 1'b0, 8'h20, 1'b0);
      i = 8'h00; tick();
      expect_out("single_iss", 3'd5, 1'b1, 8'h00, 1'b0);
      tick();
      expect_out("single_done", 3'd5, 1'b0, 8'h00, 1'b0);

      // Priority drain
      i = 8'h85; tick();
      i = 8'h00; tick();
      expect_out("drain7", 3'd7, 1'b1, 8'h05, 1'b0);
      tick();
      expect_out("drain2", 3'd2, 1'b1, 8'h01, 1'b0);
      tick();
      expect_out("drain0", 3'd0, 1'b1, 8'h00, 1'b0);
      tick();
      expect_out("drain_end", 3'd0, 1'b0, 8'h00, 1'b0);

      // Backpressure
      ack = 1'b0; i = 8'h03; tick();
      i = 8'h00; tick();
      expect_out("bp_first", 3'd1, 1'b1, 8'h01, 1'b0);
      repeat (3) tick();
      expect_out("bp_hold", 3'd1, 1'b1, 8'h01, 1'b0);
      ack = 1'b1; tick();
      expect_out("bp_ack", 3'd0, 1'b1, 8'h00, 1'b0);
      tick();
      expect_out("bp_end", 3'd0, 1'b0, 8'h00, 1'b0);

      // Overflow and clear
      ack = 1'b0; i = 8'h10; tick();
      expect_out("ovf_cap", 3'd0, 1'b0, 8'h10, 1'b0);
      tick();
      expect_out("ovf_second", 3'd4, 1'b1, 8'h10, 1'b0);
      tick();
      expect_out("ovf_set", 3'd4, 1'b1, 8'h10, 1'b1);
      i = 8'h00; clr = 1'b1; tick();
      expect_out("ovf_clr", 3'd4, 1'b1, 8'h10, 1'b0);
      clr = 1'b0; ack = 1'b1; tick();
      expect_out("ovf_drain", 3'd4, 1'b1, 8'h00, 1'b0);
      tick();
      expect_out("ovf_end", 3'd4, 1'b0, 8'h00, 1'b0);

      // Set wins over clear of the issued bit
      i = 8'h08; tick();
      tick();
      expect_out("setwin", 3'd3, 1'b1, 8'h08, 1'b0);
      i = 8'h00; tick();
      expect_out("setwin_again", 3'd3, 1'b1, 8'h00, 1'b0);

      // Enable low: pend frozen, ack still retires the valid code
      ack = 1'b0; i = 8'h40; tick();
      expect_out("en_prep", 3'd3, 1'b1, 8'h40, 1'b0);
      en = 1'b0; i = 8'hFF; ack = 1'b1; tick();
      expect_out("en_off", 3'd3, 1'b0, 8'h40, 1'b0);
      tick();
      expect_out("en_off2", 3'd3, 1'b0, 8'h40, 1'b0);
      en = 1'b1; i = 8'h00; tick();
      expect_out("en_on", 3'd6, 1'b1, 8'h00, 1'b0);
      tick();

      // Reset mid-stream
      ack = 1'b0; i = 8'hF0; tick();
      i = 8'h80; tick();
      expect_out("pre_rst", 3'd7, 1'b1, 8'hF0, 1'b0);
      i = 8'h00;
      rst_n = 1'b0;
      #1;
      expect_out("mid_rst", 3'd0, 1'b0, 8'h00, 1'b0);
      #1 rst_n = 1'b1;
      tick();
      expect_out("post_rst", 3'd0, 1'b0, 8'h00, 1'b0);

      // Randomized phase
      for (int c = 0; c < 3000; c++) begin
         logic [7:0] r;
         r   = 8'($urandom);
         i   = ($urandom_range(0, 2) == 0) ? r : (r & 8'($urandom));
         en  = ($urandom_range(0, 9) != 0);
         ack = ($urandom_range(0, 2) != 0);
         clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         tick();
      end

      i = 8'h00; en = 1'b1; ack = 1'b1; clr = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
